// File: rtl/vend_ctrl.sv
// vend_ctrl: coin vending sequencing controller.
// Accumulates coin credit, accepts an item A/B selection, runs a req/ack
// handshake with the dispenser and pays leftover credit back as one-unit
// change pulses. Cancel or an idle timeout in CREDIT refunds everything.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   coin[1:0]    01 = 1 unit, 10 = 2 units, 11 invalid, 00 none (per-cycle strobe)
//   sel[1:0]     01 item A, 10 item B, 00/11 no selection
//   cancel       refund request, sampled every cycle
//   disp_ack     dispenser done
//   disp_req     dispense request, held until ack
//   disp_item    selected item, valid while disp_req = 1
//   change       one pulse per unit returned
//   coin_reject  one-cycle pulse when a coin is not credited
//   credit       current credit
//   busy         high while dispensing or paying change
module vend_ctrl #(
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned PRICE_A    = 3,
  parameter int unsigned PRICE_B    = 4,
  parameter int unsigned MAX_CREDIT = 7,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [1:0]          disp_item,
  output logic                change,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned SUM_W  = CREDIT_W + 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt, tcnt_inc;
  logic [SUM_W-1:0]    coin_val, coin_sum;
  logic [CREDIT_W-1:0] price;
  logic                coin_ok, sel_ok, tmo_hit;

  logic [CREDIT_W-1:0] credit_nxt;
  logic                disp_req_nxt, change_nxt, coin_reject_nxt, busy_nxt;
  logic [1:0]          disp_item_nxt;

  // Coin value and overflow check in a sum one bit wider than credit
  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = SUM_W'(1);
      2'b10:   coin_val = SUM_W'(2);
      default: coin_val = '0;
    endcase
    coin_sum = {1'b0, credit} + coin_val;
    coin_ok  = (coin_val != '0) && (coin_sum <= SUM_W'(MAX_CREDIT));
  end

  // Selection is acted on only when it names an item the credit can pay for
  always_comb begin
    price  = (sel == 2'b01) ? CREDIT_W'(PRICE_A) : CREDIT_W'(PRICE_B);
    sel_ok = ((sel == 2'b01) || (sel == 2'b10)) && (credit >= price);
  end

  assign tcnt_inc = tcnt + TCNT_W'(1);
  assign tmo_hit  = (tcnt_inc == TCNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (coin_ok) state_nxt = S_CREDIT;
      end
      S_CREDIT: begin
        if (cancel)                 state_nxt = S_CHANGE;
        else if (sel_ok)            state_nxt = S_DISPENSE;
        else if (!coin_ok && tmo_hit) state_nxt = S_CHANGE;
      end
      S_DISPENSE: begin
        if (disp_ack) state_nxt = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        if (credit == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, credit and timeout counter
  always_comb begin
    credit_nxt      = credit;
    tcnt_nxt        = tcnt;
    disp_req_nxt    = disp_req;
    disp_item_nxt   = disp_item;
    change_nxt      = 1'b0;
    coin_reject_nxt = (coin != 2'b00);
    busy_nxt        = (state_nxt == S_DISPENSE) || (state_nxt == S_CHANGE);
    case (state)
      S_IDLE: begin
        tcnt_nxt = '0;
        if (coin_ok) begin
          credit_nxt      = coin_sum[CREDIT_W-1:0];
          coin_reject_nxt = 1'b0;
        end
      end
      S_CREDIT: begin
        // cancel > valid selection > coin; a coin alongside either is rejected
        if (cancel) begin
          tcnt_nxt = '0;
        end else if (sel_ok) begin
          credit_nxt    = credit - price;
          disp_req_nxt  = 1'b1;
          disp_item_nxt = sel;
          tcnt_nxt      = '0;
        end else if (coin_ok) begin
          credit_nxt      = coin_sum[CREDIT_W-1:0];
          coin_reject_nxt = 1'b0;
          tcnt_nxt        = '0;
        end else begin
          tcnt_nxt = tmo_hit ? '0 : tcnt_inc;
        end
      end
      S_DISPENSE: begin
        if (disp_ack) begin
          disp_req_nxt  = 1'b0;
          disp_item_nxt = 2'b00;
        end
      end
      S_CHANGE: begin
        if (credit != '0) begin
          change_nxt = 1'b1;
          credit_nxt = credit - CREDIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit      <= '0;
      tcnt        <= '0;
      disp_req    <= 1'b0;
      disp_item   <= 2'b00;
      change      <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      credit      <= credit_nxt;
      tcnt        <= tcnt_nxt;
      disp_req    <= disp_req_nxt;
      disp_item   <= disp_item_nxt;
      change      <= change_nxt;
      coin_reject <= coin_reject_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
